// File: rtl/key_pkg.sv
// Shared types and constants for the four-key pushbutton debouncer.
package key_pkg;

    localparam int unsigned NUM_KEYS  = 4;
    localparam int unsigned KEY_UP    = 0;
    localparam int unsigned KEY_DOWN  = 1;
    localparam int unsigned KEY_LEFT  = 2;
    localparam int unsigned KEY_RIGHT = 3;

    // Stopwatch hookup: left toggles run, up clears, down pauses.
    localparam int unsigned SW_EN_KEY    = KEY_LEFT;
    localparam int unsigned SW_CLEAR_KEY = KEY_UP;
    localparam int unsigned SW_PAUSE_KEY = KEY_DOWN;

    typedef enum logic [1:0] {
        StIdle,
        StPressWait,
        StPressed,
        StReleaseWait
    } key_st_t;

endpackage

// File: rtl/key_debounce_if.sv
// Pushbutton bundle: raw keys in, debounced pulse/level/long-press out.
interface key_debounce_if;

    logic [key_pkg::NUM_KEYS-1:0] key_in;
    logic [key_pkg::NUM_KEYS-1:0] key_pulse;
    logic [key_pkg::NUM_KEYS-1:0] key_state;
    logic [key_pkg::NUM_KEYS-1:0] key_long;

    modport master (
        output key_in,
        input  key_pulse,
        input  key_state,
        input  key_long
    );

    modport slave (
        input  key_in,
        output key_pulse,
        output key_state,
        output key_long
    );

endinterface

// File: rtl/key_debounce_ch.sv
// One debounce channel: 2-flop synchronizer, press/release FSM, optional long-press timer.
// The long-press timer is built only when KEY_LONG_PRESS_EN is defined.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 2000000,
    parameter int unsigned LONG_CYCLES     = 100000000
) (
    input  logic clk_100mhz,
    input  logic rst,
    input  logic i_key,
    output logic o_pulse,
    output logic o_state,
    output logic o_long
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 2");
    end
    if (LONG_CYCLES < 1) begin : g_bad_long
        $error("LONG_CYCLES must be at least 1");
    end

    logic             r_sync1, r_sync2, w_key_sync;
    key_st_t          r_st, w_st_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_pulse, w_pulse_nxt;
    logic             r_state;

    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_key;
            r_sync2 <= r_sync1;
        end
    end

    assign w_key_sync = r_sync2;

    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            r_st    <= StIdle;
            r_cnt   <= '0;
            r_pulse <= 1'b0;
            r_state <= 1'b0;
        end else begin
            r_st    <= w_st_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pulse <= w_pulse_nxt;
            r_state <= (w_st_nxt == StPressed) || (w_st_nxt == StReleaseWait);
        end
    end

    // The counter stops at CNT_LAST because reaching it always leaves the wait state.
    always_comb begin
        w_st_nxt    = r_st;
        w_cnt_nxt   = r_cnt;
        w_pulse_nxt = 1'b0;
        unique case (r_st)
            StIdle: begin
                if (w_key_sync) begin
                    w_st_nxt  = StPressWait;
                    w_cnt_nxt = '0;
                end
            end
            StPressWait: begin
                if (!w_key_sync) begin
                    w_st_nxt = StIdle;
                end else if (r_cnt >= CNT_LAST) begin
                    w_st_nxt    = StPressed;
                    w_pulse_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            StPressed: begin
                if (!w_key_sync) begin
                    w_st_nxt  = StReleaseWait;
                    w_cnt_nxt = '0;
                end
            end
            StReleaseWait: begin
                if (w_key_sync) begin
                    w_st_nxt = StPressed;
                end else if (r_cnt >= CNT_LAST) begin
                    w_st_nxt = StIdle;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_st_nxt = StIdle;
        endcase
    end

    assign o_pulse = r_pulse;
    assign o_state = r_state;

`ifdef KEY_LONG_PRESS_EN
    localparam int unsigned       LONG_W    = $clog2(LONG_CYCLES + 1);
    localparam logic [LONG_W-1:0] LONG_MAX  = LONG_W'(LONG_CYCLES);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);

    logic [LONG_W-1:0] r_long_cnt;
    logic              r_long_done, r_long, w_hold;

    // Only cycles that stay in PRESSED count; a release bounce restarts the timer.
    assign w_hold = (r_st == StPressed) && (w_st_nxt == StPressed);

    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            r_long_cnt  <= '0;
            r_long_done <= 1'b0;
            r_long      <= 1'b0;
        end else begin
            r_long <= 1'b0;
            if (!w_hold) begin
                r_long_cnt <= '0;
            end else if (r_long_cnt < LONG_MAX) begin
                r_long_cnt <= r_long_cnt + 1'b1;
            end
            if (r_st == StIdle) begin
                r_long_done <= 1'b0;
            end else if (w_hold && !r_long_done && (r_long_cnt == LONG_LAST)) begin
                r_long      <= 1'b1;
                r_long_done <= 1'b1;
            end
        end
    end

    assign o_long = r_long;
`else
    assign o_long = 1'b0;
`endif

endmodule

// File: rtl/key_debounce.sv
// Four independent pushbutton debounce channels behind a key_debounce_if port.
// Define KEY_LONG_PRESS_EN to enable key_long; otherwise it is tied low.
module key_debounce
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 2000000,
    parameter int unsigned LONG_CYCLES     = 100000000
) (
    input  logic          clk_100mhz,
    input  logic          rst,
    key_debounce_if.slave keys
);

    logic [NUM_KEYS-1:0] w_pulse;
    logic [NUM_KEYS-1:0] w_state;
    logic [NUM_KEYS-1:0] w_long;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES)
        ) u_ch (
            .clk_100mhz (clk_100mhz),
            .rst        (rst),
            .i_key      (keys.key_in[g]),
            .o_pulse    (w_pulse[g]),
            .o_state    (w_state[g]),
            .o_long     (w_long[g])
        );
    end

    assign keys.key_pulse = w_pulse;
    assign keys.key_state = w_state;
    assign keys.key_long  = w_long;

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce: directed scenarios plus randomized key traffic
// checked every cycle against a run-length reference model.
module tb_key_debounce;

    localparam int unsigned DEB = 8;
    localparam int unsigned LNG = 40;

    logic clk;
    logic rst;

    key_debounce_if u_if ();

    key_debounce #(
        .DEBOUNCE_CYCLES (DEB),
        .LONG_CYCLES     (LNG)
    ) u_dut (
        .clk_100mhz (clk),
        .rst        (rst),
        .keys       (u_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: a key's level flips once key_sync (key_in two edges late) has
    // differed from the level for DEB+1 consecutive edges; long press counts edges held.
    logic [3:0] m_s1, m_s2;
    int         m_run   [4];
    int         m_long  [4];
    bit         m_lvl   [4];
    bit         m_done  [4];
    bit         m_sprev [4];
    logic [3:0] e_pulse, e_state, e_long;

    task automatic model_step();
        logic [3:0] s;
        bit         held_before;
        e_pulse = '0;
        e_long  = '0;
        if (rst) begin
            m_s1 = '0;
            m_s2 = '0;
            for (int k = 0; k < 4; k++) begin
                m_run[k] = 0; m_long[k] = 0; m_lvl[k] = 0; m_done[k] = 0; m_sprev[k] = 0;
            end
        end else begin
            s    = m_s2;
            m_s2 = m_s1;
            m_s1 = u_if.key_in;
            for (int k = 0; k < 4; k++) begin
                held_before = m_lvl[k] && m_sprev[k];
                if (s[k] != m_lvl[k]) begin
                    m_run[k]++;
                    if (m_run[k] == DEB + 1) begin
                        m_lvl[k] = s[k];
                        m_run[k] = 0;
                        if (s[k]) e_pulse[k] = 1'b1;
                        else      m_done[k]  = 0;
                    end
                end else begin
                    m_run[k] = 0;
                end
                if (m_lvl[k] && held_before && s[k]) begin
                    if (m_long[k] < LNG) m_long[k]++;
                    if (m_long[k] == LNG && !m_done[k]) begin
                        e_long[k] = 1'b1;
                        m_done[k] = 1;
                    end
                end else begin
                    m_long[k] = 0;
                end
                m_sprev[k] = s[k];
            end
        end
        for (int k = 0; k < 4; k++) e_state[k] = m_lvl[k];
`ifndef KEY_LONG_PRESS_EN
        e_long = '0;
`endif
    endtask

    // Event bookkeeping used by the directed scenarios.
    int   edge_n = 0;
    int   n_pulse [4];
    int   n_rise  [4];
    int   n_long  [4];
    int   pulse_edge [4];
    int   long_edge  [4];
    int   fall_edge  [4];
    logic [3:0] prev_state = '0;
    bit   saw_all = 0;

    initial begin
        for (int k = 0; k < 4; k++) begin
            n_pulse[k] = 0; n_rise[k] = 0; n_long[k] = 0;
            pulse_edge[k] = 0; long_edge[k] = 0; fall_edge[k] = 0;
        end
    end

    always @(posedge clk) begin
        #1;
        edge_n++;
        model_step();
        check_eq("cyc_key_pulse", 32'(u_if.key_pulse), 32'(e_pulse));
        check_eq("cyc_key_state", 32'(u_if.key_state), 32'(e_state));
        check_eq("cyc_key_long",  32'(u_if.key_long),  32'(e_long));
        if (u_if.key_pulse == 4'hF) saw_all = 1;
        for (int k = 0; k < 4; k++) begin
            if (u_if.key_pulse[k]) begin n_pulse[k]++; pulse_edge[k] = edge_n; end
            if (u_if.key_long[k])  begin n_long[k]++;  long_edge[k]  = edge_n; end
            if (u_if.key_state[k] && !prev_state[k]) n_rise[k]++;
            if (!u_if.key_state[k] && prev_state[k]) fall_edge[k] = edge_n;
        end
        prev_state = u_if.key_state;
    end

    int e0;
    int p0;
    int r0;
    int seg_left [4];

    initial begin
        rst         = 1'b1;
        u_if.key_in = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_key_pulse", 32'(u_if.key_pulse), 0);
        check_eq("rst_key_state", 32'(u_if.key_state), 0);
        check_eq("rst_key_long",  32'(u_if.key_long),  0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Clean press on key 0.
        e0 = edge_n; p0 = n_pulse[0];
        u_if.key_in[0] = 1'b1;
        repeat (20) @(negedge clk);
        check_eq("clean_pulse_count", 32'(n_pulse[0] - p0), 1);
        check_eq("clean_latency", 32'(pulse_edge[0] - e0), 11);
        check_eq("clean_state_held", 32'(u_if.key_state[0]), 1);

        // Release bounce: 4 cycles low, 4 high, then stable low.
        p0 = n_pulse[0];
        u_if.key_in[0] = 1'b0;
        repeat (4) @(negedge clk);
        u_if.key_in[0] = 1'b1;
        repeat (4) @(negedge clk);
        e0 = edge_n;
        u_if.key_in[0] = 1'b0;
        repeat (20) @(negedge clk);
        check_eq("relbounce_no_pulse", 32'(n_pulse[0] - p0), 0);
        check_eq("relbounce_fall_latency", 32'(fall_edge[0] - e0), 11);

        // Press bounce on key 2: toggle every 3 cycles for 30 cycles.
        p0 = n_pulse[2]; r0 = n_rise[2];
        for (int i = 0; i < 10; i++) begin
            u_if.key_in[2] = ~u_if.key_in[2];
            repeat (3) @(negedge clk);
        end
        u_if.key_in[2] = 1'b0;
        repeat (20) @(negedge clk);
        check_eq("bounce_no_pulse", 32'(n_pulse[2] - p0), 0);
        check_eq("bounce_no_state", 32'(n_rise[2] - r0), 0);

        // Simultaneous press of all four keys.
        e0 = edge_n; saw_all = 0;
        u_if.key_in = 4'hF;
        repeat (20) @(negedge clk);
        check_eq("simul_same_cycle", 32'(saw_all), 1);
        for (int k = 0; k < 4; k++) check_eq("simul_latency", 32'(pulse_edge[k] - e0), 11);
        u_if.key_in = '0;
        repeat (20) @(negedge clk);

        // Asynchronous reset while key 0 is held and accepted.
        u_if.key_in[0] = 1'b1;
        repeat (20) @(negedge clk);
        check_eq("pre_rst_state", 32'(u_if.key_state[0]), 1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_eq("async_rst_state", 32'(u_if.key_state), 0);
        check_eq("async_rst_pulse", 32'(u_if.key_pulse), 0);
        repeat (2) @(negedge clk);
        e0 = edge_n; p0 = n_pulse[0];
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check_eq("post_rst_pulse_count", 32'(n_pulse[0] - p0), 1);
        check_eq("post_rst_latency", 32'(pulse_edge[0] - e0), 11);
        u_if.key_in[0] = 1'b0;
        repeat (20) @(negedge clk);

        // Reset around edge 5 of a debounce on key 3.
        p0 = n_pulse[3];
        u_if.key_in[3] = 1'b1;
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_eq("middeb_rst_state", 32'(u_if.key_state[3]), 0);
        repeat (2) @(negedge clk);
        e0 = edge_n;
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check_eq("middeb_pulse_count", 32'(n_pulse[3] - p0), 1);
        check_eq("middeb_latency", 32'(pulse_edge[3] - e0), 11);
        u_if.key_in[3] = 1'b0;
        repeat (20) @(negedge clk);

        // Long press on key 1: held 100 cycles.
        p0 = n_long[1];
        u_if.key_in[1] = 1'b1;
        repeat (100) @(negedge clk);
        u_if.key_in[1] = 1'b0;
        repeat (20) @(negedge clk);
`ifdef KEY_LONG_PRESS_EN
        check_eq("long_count", 32'(n_long[1] - p0), 1);
        check_eq("long_delay", 32'(long_edge[1] - pulse_edge[1]), LNG);
`else
        check_eq("long_absent", 32'(n_long[1] - p0), 0);
`endif

        // Randomized key traffic with occasional resets.
        for (int k = 0; k < 4; k++) seg_left[k] = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 599) == 0) begin
                rst = 1'b1;
                repeat (2) @(negedge clk);
                rst = 1'b0;
            end
            for (int k = 0; k < 4; k++) begin
                if (seg_left[k] == 0) begin
                    u_if.key_in[k] = 1'($urandom_range(0, 1));
                    seg_left[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 60))
                                                              : int'($urandom_range(1, 10));
                end
                seg_left[k]--;
            end
        end
        u_if.key_in = '0;
        repeat (20) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 2000000: stable cycles needed to accept a level change (20 ms at 100 MHz); legal range is 2 or more.
REQ-002 SHALL have parameter LONG_CYCLES, default 100000000: held cycles before a long-press pulse (1 s at 100 MHz).
REQ-003 SHALL have port clk_100mhz  input  1: sole clock, rising edge.
REQ-004 SHALL have port rst  input  1: asynchronous, active-high reset.
REQ-005 SHALL have port key_in  input  4: raw pushbuttons, pressed = 1; bit 0 up, 1 down, 2 left, 3 right.
REQ-006 SHALL have port key_pulse  output  4: one-cycle pulse per accepted press.
REQ-007 SHALL have port key_state  output  4: debounced level, 1 while held.
REQ-008 SHALL have port key_long  output  4: one-cycle pulse on long press.
REQ-009 SHALL use one clock, clk_100mhz, with asynchronous active-high reset rst.

Function
REQ-010 SHALL pass each key_in bit through a 2-flop synchronizer (key_sync) before any use.
REQ-011 SHALL run one independent FSM per key: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-012 SHALL move IDLE->PRESS_WAIT when key_sync=1, clearing the debounce counter.
REQ-013 SHALL, in PRESS_WAIT, return to IDLE when key_sync=0 (bounce rejected, no pulse), and move to PRESSED once key_sync has been 1 for DEBOUNCE_CYCLES consecutive cycles.
REQ-014 SHALL assert key_pulse[i] for exactly one cycle, registered, in the cycle after entering PRESSED.
REQ-015 SHALL make total press latency exactly DEBOUNCE_CYCLES+3 clk_100mhz edges from the first edge sampling key_in[i]=1.
REQ-016 SHALL move PRESSED->RELEASE_WAIT when key_sync=0, clearing the debounce counter.
REQ-017 SHALL, in RELEASE_WAIT, return to PRESSED when key_sync=1 with no new key_pulse, and move to IDLE after DEBOUNCE_CYCLES consecutive key_sync=0.
REQ-018 SHALL drive key_state[i]=1 in PRESSED and RELEASE_WAIT, and 0 otherwise (registered).
REQ-019 SHALL size the debounce counter at $clog2(DEBOUNCE_CYCLES+1) bits; it saturates, never wraps.
REQ-020 SHALL treat keys as fully independent; simultaneous presses produce simultaneous pulses in the same cycle.
REQ-021 SHALL NOT generate a pulse for any glitch shorter than DEBOUNCE_CYCLES, regardless of glitch count.

Reset
REQ-022 SHALL, on rst=1, immediately (asynchronously) force all FSMs to IDLE, clear counters and synchronizers, and drive key_pulse, key_state and key_long to 0.
REQ-023 SHALL NOT emit a pulse on rst deassertion while a key is held; the press is accepted only after the full debounce from IDLE.
REQ-024 SHALL abort an in-progress debounce without output when rst is asserted mid-operation.

Configuration
REQ-025 SHALL, with macro KEY_LONG_PRESS_EN defined, count cycles in PRESSED, pulse key_long[i] for one cycle when the count reaches LONG_CYCLES, emit only one long pulse per press, and clear the count on entering RELEASE_WAIT.
REQ-026 SHALL, without KEY_LONG_PRESS_EN, keep port key_long present, tie it to 0, and omit the long counters from the logic.

Structure
REQ-027 SHALL place the FSM state enum (key_st_t), the key index constants KEY_UP=0, KEY_DOWN=1, KEY_LEFT=2, KEY_RIGHT=3, and the key count NUM_KEYS=4 in shared package key_pkg.
REQ-028 SHALL implement one channel as sub-module key_debounce_ch (synchronizer + FSM + counters), instantiated NUM_KEYS times.
REQ-029 SHALL feed key_pulse[KEY_LEFT], key_pulse[KEY_UP] and key_pulse[KEY_DOWN] to the stopwatch sw_en, clear and pause inputs.

Verification (bench: DEBOUNCE_CYCLES=8, LONG_CYCLES=40)
REQ-030 SHALL cover a clean press: key_in[0] 0->1 held -> key_pulse[0]=1 for one cycle at edge 11 and key_state[0]=1 from the same cycle.
REQ-031 SHALL cover bounce: key_in[2] toggled every 3 cycles for 30 cycles, then 0 -> key_pulse and key_state stay 0 throughout.
REQ-032 SHALL cover release bounce: held key released with a 4-cycle 0 then 1 then stable 0 -> no second pulse, and key_state falls 11 edges after the final release.
REQ-033 SHALL cover simultaneous presses: key_in=4'b1111 at one edge -> key_pulse=4'b1111 in a single cycle at edge 11.
REQ-034 SHALL cover reset mid-debounce: rst pulsed at edge 5 while the key is held -> outputs 0 immediately, then a pulse 11 edges after rst deasserts.
REQ-035 SHALL cover long press with KEY_LONG_PRESS_EN: key_in[1] held 100 cycles -> exactly one key_long[1] pulse, 40 cycles after key_pulse[1]; without the macro key_long stays 0.
